// File: rtl/pattern_scan_ctrl_if.sv
// Word stream handshake between a producer and pattern_scan_ctrl.
// The producer drives valid/data/last and holds them until ready.
interface pattern_scan_ctrl_if #(
    parameter int WORD_W = 8
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serialises words MSB-first into a programmable sequence detector,
// counting overlapping matches per frame and reporting with a done pulse.
module pattern_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_W-1:0]   cfg_pattern,
    pattern_scan_ctrl_if.slave in_if,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [7:0]         match_count,
    output logic [15:0]        first_pos
);

    localparam int CW = $clog2(WORD_W);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [PAT_W-1:0] PAT_RST =
        {1'b1, {(PAT_W-1){1'b0}}} | PAT_W'(1);

    logic [1:0]        state;
    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  hist;
    logic [WORD_W-1:0] sreg;
    logic [CW-1:0]     bit_cnt;
    logic [15:0]       frame_cnt;
    logic              last_q;
    logic              frame_open;

    logic              scan_bit;
    logic [PAT_W-1:0]  hist_nxt;
    logic [15:0]       cnt_nxt;
    logic              hit;

    assign scan_bit = sreg[WORD_W-1];
    assign hist_nxt = {hist[PAT_W-2:0], scan_bit};
    assign cnt_nxt  = (frame_cnt == 16'hFFFF) ? frame_cnt
                                              : frame_cnt + 16'd1;
    // A full pattern's worth of frame bits must exist before a match counts
    assign hit = (hist_nxt == pattern) && (cnt_nxt >= 16'(PAT_W));

    assign in_if.in_ready = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_REPORT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pattern     <= PAT_RST;
            hist        <= '0;
            sreg        <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            last_q      <= 1'b0;
            frame_open  <= 1'b0;
            found       <= 1'b0;
            match_count <= '0;
            first_pos   <= '0;
        end else begin
            if (state == S_IDLE && cfg_we)
                pattern <= cfg_pattern;

            unique case (state)
                S_IDLE: begin
                    if (in_if.in_valid) begin
                        sreg    <= in_if.in_data;
                        last_q  <= in_if.in_last;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                        if (!frame_open) begin
                            hist        <= '0;
                            frame_cnt   <= '0;
                            match_count <= '0;
                            found       <= 1'b0;
                            first_pos   <= '0;
                            frame_open  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    sreg      <= {sreg[WORD_W-2:0], 1'b0};
                    hist      <= hist_nxt;
                    frame_cnt <= cnt_nxt;
                    bit_cnt   <= bit_cnt + CW'(1);
                    if (hit) begin
                        if (match_count != 8'hFF)
                            match_count <= match_count + 8'd1;
                        if (!found) begin
                            found     <= 1'b1;
                            first_pos <= frame_cnt;
                        end
                    end
                    if (bit_cnt == CW'(WORD_W-1))
                        state <= last_q ? S_REPORT : S_IDLE;
                end
                S_REPORT: begin
                    frame_open <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomised and directed checks of pattern_scan_ctrl against a
// frame-level model that rescans the recorded bit stream at frame end.
module tb_pattern_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic             busy;
    logic             done;
    logic             found;
    logic [7:0]       match_count;
    logic [15:0]      first_pos;

    pattern_scan_ctrl_if #(.WORD_W(WORD_W)) sif ();

    pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .in_if       (sif.slave),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .match_count (match_count),
        .first_pos   (first_pos)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic             bits[$];
    logic [PAT_W-1:0] pats[$];
    logic [PAT_W-1:0] cur_pat;

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_result(output int cnt, output int fp,
                                output int f);
        logic [PAT_W-1:0] w;
        cnt = 0;
        fp  = 0;
        f   = 0;
        for (int i = PAT_W - 1; i < bits.size(); i++) begin
            for (int j = 0; j < PAT_W; j++)
                w[PAT_W-1-j] = bits[i-PAT_W+1+j];
            if (w == pats[i]) begin
                if (f == 0) begin
                    f  = 1;
                    fp = i;
                end
                cnt++;
            end
        end
        if (cnt > 255) cnt = 255;
    endtask

    task automatic do_cfg(input logic [PAT_W-1:0] p);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        @(posedge clk);
        if (sif.in_ready) cur_pat = p;
        #1 cfg_we = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input logic l,
                             input logic with_cfg,
                             input logic [PAT_W-1:0] cp,
                             input logic spur);
        int to = 0;
        int low = 0;
        int m_cnt, m_fp, m_f;
        @(negedge clk);
        while (!sif.in_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) check("ready_timeout", 0, 1);
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        sif.in_last  = l;
        cfg_we       = with_cfg;
        cfg_pattern  = cp;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        cfg_we       = 1'b0;
        if (with_cfg) cur_pat = cp;
        for (int k = WORD_W - 1; k >= 0; k--) begin
            bits.push_back(d[k]);
            pats.push_back(cur_pat);
        end
        for (int k = 1; k <= WORD_W; k++) begin
            @(negedge clk);
            if (!sif.in_ready && busy && !done) low++;
            cfg_we = 1'b0;
            if (spur && k == 3) begin
                cfg_we       = 1'b1;
                cfg_pattern  = ~cur_pat;
                sif.in_valid = 1'b1;
                sif.in_data  = ~d;
            end
            if (k == WORD_W) sif.in_valid = 1'b0;
        end
        check("ready_low_cycles", low, WORD_W);
        @(negedge clk);
        if (l) begin
            check("done_pulse", {done, sif.in_ready}, 2'b10);
            model_result(m_cnt, m_fp, m_f);
            check("found", found, m_f);
            check("match_count", match_count, m_cnt);
            if (m_f != 0) check("first_pos", first_pos, m_fp);
            @(negedge clk);
            check("after_done", {done, sif.in_ready, busy}, 3'b010);
            check("hold_count", match_count, m_cnt);
            bits.delete();
            pats.delete();
        end else begin
            check("nonlast_idle", {done, sif.in_ready}, 2'b01);
        end
    endtask

    task automatic check_idle_clear(input string tag);
        check(tag, {sif.in_ready, busy, done, found, match_count,
                    first_pos}, {3'b100, 1'b0, 8'd0, 16'd0});
    endtask

    initial begin
        int nw, dcnt;
        logic [WORD_W-1:0] d;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        sif.in_last  = 1'b0;
        cur_pat      = 4'b1001;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_clear("reset_defaults");

        send_word(8'b1001_0000, 1'b1, 1'b0, '0, 1'b0);
        check("single_exact", {match_count, first_pos}, {8'd1, 16'd3});
        send_word(8'b1001_0010, 1'b1, 1'b0, '0, 1'b0);
        check("overlap_exact", {match_count, first_pos}, {8'd2, 16'd3});
        send_word(8'h02, 1'b0, 1'b0, '0, 1'b0);
        send_word(8'h40, 1'b1, 1'b0, '0, 1'b0);
        check("cross_exact", {match_count, first_pos}, {8'd1, 16'd9});

        do_cfg(4'b1111);
        send_word(8'hFF, 1'b1, 1'b0, '0, 1'b1);
        check("reconf_exact", {match_count, first_pos}, {8'd5, 16'd3});
        send_word(8'hFF, 1'b1, 1'b0, '0, 1'b0);
        check("cfg_ignored", match_count, 5);

        // Reset while the fourth bit of a frame is being scanned
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = 8'hFF;
        sif.in_last  = 1'b1;
        @(posedge clk);
        #1 sif.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle_clear("reset_mid_shift");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bits.delete();
        pats.delete();
        cur_pat = 4'b1001;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("no_done_after_reset", dcnt, 0);
        send_word(8'b1001_0000, 1'b1, 1'b0, '0, 1'b0);
        check("post_reset_exact", {match_count, first_pos},
              {8'd1, 16'd3});

        for (int fr = 0; fr < 40; fr++) begin
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 4) == 0)
                    do_cfg(PAT_W'($urandom));
                d = WORD_W'($urandom);
                send_word(d, w == nw - 1, $urandom_range(0, 5) == 0,
                          PAT_W'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
